// File: rtl/mycpu_pkg.sv
// Shared CPU types: memory-op encoding, bus size codes and exception flags.
`default_nettype none

package mycpu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_LWL  = 4'd6,
        MEM_LWR  = 4'd7,
        MEM_SB   = 4'd8,
        MEM_SH   = 4'd9,
        MEM_SW   = 4'd10,
        MEM_SWL  = 4'd11,
        MEM_SWR  = 4'd12
    } mem_op_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic adel;
        logic ades;
    } mem_exc_t;

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR};
    endfunction

    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW, MEM_SWL, MEM_SWR};
    endfunction

    // Unaligned LWL/LWR/SWL/SWR are legal by construction; only natural-size ops can fault.
    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return a[0];
            MEM_LW, MEM_SW:          return |a;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// Load result formatting: byte/half select with extension and LWL/LWR merge with old rt.
`default_nettype none

module lsu_load_align
    import mycpu_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] mem_i,
    input  logic [31:0] rt_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_i[8*offset_i +: 8];
        half_sel = offset_i[1] ? mem_i[31:16] : mem_i[15:0];
        data_o   = '0;
        case (op_i)
            MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_o = {24'd0, byte_sel};
            MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_o = {16'd0, half_sel};
            MEM_LW:  data_o = mem_i;
            MEM_LWL: begin
                case (offset_i)
                    2'd0:    data_o = {mem_i[7:0],  rt_i[23:0]};
                    2'd1:    data_o = {mem_i[15:0], rt_i[15:0]};
                    2'd2:    data_o = {mem_i[23:0], rt_i[7:0]};
                    default: data_o = mem_i;
                endcase
            end
            MEM_LWR: begin
                case (offset_i)
                    2'd0:    data_o = mem_i;
                    2'd1:    data_o = {rt_i[31:24], mem_i[31:8]};
                    2'd2:    data_o = {rt_i[31:16], mem_i[31:16]};
                    default: data_o = {rt_i[31:8],  mem_i[31:24]};
                endcase
            end
            default: data_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_lsu.sv
// Load/store unit: one op at a time through IDLE/REQ/WAIT/DONE, with alignment exceptions.
`default_nettype none

module memory_lsu
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  mem_op_t     in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_rt_old,
    output logic        dreq_valid,
    output logic [31:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [3:0]  dreq_strobe,
    output logic [31:0] dreq_data,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [31:0] dresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_exc_adel,
    output logic        out_exc_ades,
    output logic [31:0] out_badvaddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_old_q, rt_old_d;
    logic [31:0] rdata_q, rdata_d;
    mem_exc_t    exc_q, exc_d;

    logic [1:0]  a;
    logic [4:0]  swl_shamt;
    logic [31:0] load_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= MEM_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_old_q <= '0;
            rdata_q  <= '0;
            exc_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_old_q <= rt_old_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rt_old_d   = rt_old_q;
        rdata_d    = rdata_q;
        exc_d      = exc_q;
        in_ready   = 1'b0;
        dreq_valid = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_d     = in_op;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    rt_old_d = in_rt_old;
                    rdata_d  = '0;
                    exc_d    = '0;
                    if (in_op == MEM_NONE) begin
                        state_d = S_DONE;
                    end else if (is_misaligned(in_op, in_addr[1:0])) begin
                        exc_d.adel = is_load(in_op);
                        exc_d.ades = is_store(in_op);
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                dreq_valid = 1'b1;
                if (dresp_addr_ok) begin
                    if (dresp_data_ok) begin
                        rdata_d = dresp_data;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    rdata_d = dresp_data;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are held at zero outside REQ so the bus sees clean idle values.
    always_comb begin
        a           = addr_q[1:0];
        swl_shamt   = {2'd3 - a, 3'b000};
        dreq_addr   = '0;
        dreq_size   = SIZE_BYTE;
        dreq_strobe = 4'b0000;
        dreq_data   = '0;
        if (state_q == S_REQ) begin
            dreq_addr = addr_q;
            case (op_q)
                MEM_LB, MEM_LBU: dreq_size = SIZE_BYTE;
                MEM_LH, MEM_LHU: dreq_size = SIZE_HALF;
                MEM_LW:          dreq_size = SIZE_WORD;
                MEM_LWL, MEM_LWR: begin
                    dreq_size = SIZE_WORD;
                    dreq_addr = {addr_q[31:2], 2'b00};
                end
                MEM_SB: begin
                    dreq_size   = SIZE_BYTE;
                    dreq_strobe = 4'b0001 << a;
                    dreq_data   = {4{wdata_q[7:0]}};
                end
                MEM_SH: begin
                    dreq_size   = SIZE_HALF;
                    dreq_strobe = 4'b0011 << a;
                    dreq_data   = {2{wdata_q[15:0]}};
                end
                MEM_SW: begin
                    dreq_size   = SIZE_WORD;
                    dreq_strobe = 4'b1111;
                    dreq_data   = wdata_q;
                end
                MEM_SWL: begin
                    dreq_size   = SIZE_WORD;
                    dreq_addr   = {addr_q[31:2], 2'b00};
                    dreq_strobe = 4'b1111 >> (2'd3 - a);
                    dreq_data   = wdata_q >> swl_shamt;
                end
                MEM_SWR: begin
                    dreq_size   = SIZE_WORD;
                    dreq_addr   = {addr_q[31:2], 2'b00};
                    dreq_strobe = 4'b1111 << a;
                    dreq_data   = wdata_q << {a, 3'b000};
                end
                default: dreq_addr = '0;
            endcase
        end
    end

    lsu_load_align u_load_align (
        .op_i     (op_q),
        .offset_i (addr_q[1:0]),
        .mem_i    (rdata_q),
        .rt_i     (rt_old_q),
        .data_o   (load_data)
    );

    always_comb begin
        out_data     = '0;
        out_exc_adel = 1'b0;
        out_exc_ades = 1'b0;
        out_badvaddr = '0;
        if (state_q == S_DONE) begin
            out_exc_adel = exc_q.adel;
            out_exc_ades = exc_q.ades;
            if (exc_q.adel || exc_q.ades) begin
                out_badvaddr = addr_q;
            end else if (is_load(op_q)) begin
                out_data = load_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_lsu.sv
// Directed self-checking bench for memory_lsu with a scripted data-bus responder.
`default_nettype none

module tb_memory_lsu;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    mem_op_t     in_op = MEM_NONE;
    logic [31:0] in_addr = '0, in_wdata = '0, in_rt_old = '0;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok = 1'b0, dresp_data_ok = 1'b0;
    logic [31:0] dresp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_exc_adel, out_exc_ades;
    logic [31:0] out_badvaddr;

    int total = 0;
    int bad = 0;

    // Observations captured by run_op
    logic        saw_req, req_stable, done_stable, timed_out, ready_after;
    int          n_req, req_cycles, latency;
    logic [31:0] q_addr, q_data, q_out, q_bad;
    logic [1:0]  q_size;
    logic [3:0]  q_strobe;
    logic        q_adel, q_ades;

    memory_lsu dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rt_old(in_rt_old),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_exc_adel(out_exc_adel), .out_exc_ades(out_exc_ades), .out_badvaddr(out_badvaddr)
    );

    always #5 clk = ~clk;

    // Issues one op, answers the bus after aok_delay request cycles (data dok_gap cycles
    // after the accept), then holds out_ready low for ready_delay cycles in DONE.
    task automatic run_op(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rt, input logic [31:0] mem,
                          input int aok_delay, input int dok_gap, input int ready_delay);
        int cyc, aok_cnt, wait_cnt;
        logic in_wait;
        saw_req = 0; req_stable = 1; done_stable = 1; n_req = 0; req_cycles = 0;
        q_addr = '0; q_data = '0; q_size = '0; q_strobe = '0;
        in_valid = 1; in_op = op; in_addr = addr; in_wdata = wd; in_rt_old = rt;
        @(posedge clk); #1;
        in_valid = 0; in_op = MEM_NONE; in_addr = '0; in_wdata = '0; in_rt_old = '0;
        cyc = 0; aok_cnt = 0; wait_cnt = 0; in_wait = 0;
        while (!out_valid && cyc < 40) begin
            if (dreq_valid) begin
                req_cycles++;
                if (!saw_req) begin
                    saw_req = 1; q_addr = dreq_addr; q_data = dreq_data;
                    q_size = dreq_size; q_strobe = dreq_strobe;
                end else if (dreq_addr !== q_addr || dreq_data !== q_data ||
                             dreq_size !== q_size || dreq_strobe !== q_strobe) begin
                    req_stable = 0;
                end
                if (aok_cnt >= aok_delay) begin
                    dresp_addr_ok = 1; n_req++;
                    if (dok_gap == 0) begin dresp_data_ok = 1; dresp_data = mem; end
                    else in_wait = 1;
                end else begin
                    aok_cnt++;
                end
            end else if (in_wait) begin
                wait_cnt++;
                if (wait_cnt >= dok_gap) begin dresp_data_ok = 1; dresp_data = mem; end
            end
            @(posedge clk); #1;
            dresp_addr_ok = 0; dresp_data_ok = 0; dresp_data = '0;
            cyc++;
        end
        latency = cyc;
        timed_out = !out_valid;
        if (timed_out) begin
            total++; bad++;
            $display("FAIL timeout op=%0d got out_valid=%b expected 1", op, out_valid);
        end
        q_out = out_data; q_adel = out_exc_adel; q_ades = out_exc_ades; q_bad = out_badvaddr;
        for (int i = 0; i < ready_delay; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== q_out ||
                out_exc_adel !== q_adel || out_exc_ades !== q_ades || out_badvaddr !== q_bad)
                done_stable = 0;
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        ready_after = in_ready;
    endtask

    task automatic test_reset();
        #2;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        total++; if (dreq_valid !== 1'b0) begin bad++; $display("FAIL rst_dreq_valid got=%b exp=0", dreq_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 32'h0 || out_badvaddr !== 32'h0) begin bad++; $display("FAIL rst_data got=%h/%h exp=0/0", out_data, out_badvaddr); end
        total++; if ({out_exc_adel, out_exc_ades} !== 2'b00) begin bad++; $display("FAIL rst_exc got=%b exp=00", {out_exc_adel, out_exc_ades}); end
        total++; if (dreq_strobe !== 4'h0 || dreq_addr !== 32'h0) begin bad++; $display("FAIL rst_dreq got=%h/%h exp=0/0", dreq_strobe, dreq_addr); end
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        run_op(MEM_LW, 32'h1000, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        total++; if (q_out !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", q_out); end
        total++; if (q_strobe !== 4'b0000) begin bad++; $display("FAIL lw_strobe got=%b exp=0000", q_strobe); end
        total++; if (n_req !== 1) begin bad++; $display("FAIL lw_nreq got=%0d exp=1", n_req); end
        total++; if (q_addr !== 32'h1000 || q_size !== 2'd2) begin bad++; $display("FAIL lw_req got=%h/%0d exp=1000/2", q_addr, q_size); end
        total++; if ({q_adel, q_ades} !== 2'b00) begin bad++; $display("FAIL lw_exc got=%b exp=00", {q_adel, q_ades}); end
    endtask

    task automatic test_sb();
        run_op(MEM_SB, 32'h1003, 32'h000000A5, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_strobe !== 4'b1000) begin bad++; $display("FAIL sb_strobe got=%b exp=1000", q_strobe); end
        total++; if (q_data !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_data got=%h exp=a5a5a5a5", q_data); end
        total++; if (q_size !== 2'd0 || q_addr !== 32'h1003) begin bad++; $display("FAIL sb_req got=%0d/%h exp=0/1003", q_size, q_addr); end
        total++; if (q_out !== 32'h0 || {q_adel, q_ades} !== 2'b00 || timed_out) begin bad++; $display("FAIL sb_result got=%h/%b exp=0/00", q_out, {q_adel, q_ades}); end
    endtask

    task automatic test_misalign();
        run_op(MEM_LH, 32'h2001, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++; if ({q_adel, q_ades} !== 2'b10) begin bad++; $display("FAIL lh_exc got=%b exp=10", {q_adel, q_ades}); end
        total++; if (q_bad !== 32'h2001) begin bad++; $display("FAIL lh_badvaddr got=%h exp=2001", q_bad); end
        total++; if (saw_req !== 1'b0) begin bad++; $display("FAIL lh_noreq got=%b exp=0", saw_req); end
        run_op(MEM_SW, 32'h4002, 32'h12345678, 32'h0, 32'h0, 0, 0, 0);
        total++; if ({q_adel, q_ades} !== 2'b01 || q_bad !== 32'h4002) begin bad++; $display("FAIL sw_exc got=%b/%h exp=01/4002", {q_adel, q_ades}, q_bad); end
        total++; if (saw_req !== 1'b0 || latency !== 0) begin bad++; $display("FAIL sw_noreq got=%b/%0d exp=0/0", saw_req, latency); end
        run_op(MEM_LWL, 32'h2003, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        total++; if ({q_adel, q_ades} !== 2'b00 || saw_req !== 1'b1) begin bad++; $display("FAIL lwl_legal got=%b/%b exp=00/1", {q_adel, q_ades}, saw_req); end
    endtask

    task automatic test_loads();
        run_op(MEM_LWL, 32'h3001, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 0, 0);
        total++; if (q_out !== 32'h3344CCDD) begin bad++; $display("FAIL lwl_data got=%h exp=3344ccdd", q_out); end
        total++; if (q_addr !== 32'h3000 || q_size !== 2'd2) begin bad++; $display("FAIL lwl_req got=%h/%0d exp=3000/2", q_addr, q_size); end
        run_op(MEM_LWR, 32'h3001, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 1, 0);
        total++; if (q_out !== 32'hAA112233) begin bad++; $display("FAIL lwr_data got=%h exp=aa112233", q_out); end
        run_op(MEM_LB, 32'h1002, 32'h0, 32'h0, 32'h12803456, 0, 0, 0);
        total++; if (q_out !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", q_out); end
        run_op(MEM_LBU, 32'h1002, 32'h0, 32'h0, 32'h12803456, 0, 0, 0);
        total++; if (q_out !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", q_out); end
        run_op(MEM_LH, 32'h1002, 32'h0, 32'h0, 32'h80013456, 0, 0, 0);
        total++; if (q_out !== 32'hFFFF8001 || q_size !== 2'd1) begin bad++; $display("FAIL lh_data got=%h/%0d exp=ffff8001/1", q_out, q_size); end
        run_op(MEM_LHU, 32'h1000, 32'h0, 32'h0, 32'h1234F00D, 0, 0, 0);
        total++; if (q_out !== 32'h0000F00D) begin bad++; $display("FAIL lhu_data got=%h exp=0000f00d", q_out); end
    endtask

    task automatic test_store_lanes();
        run_op(MEM_SH, 32'h1002, 32'h1234ABCD, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_strobe !== 4'b1100 || q_data !== 32'hABCDABCD || q_size !== 2'd1) begin bad++; $display("FAIL sh_req got=%b/%h/%0d exp=1100/abcdabcd/1", q_strobe, q_data, q_size); end
        run_op(MEM_SWL, 32'h1001, 32'h11223344, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_strobe !== 4'b0011 || q_data !== 32'h00001122 || q_addr !== 32'h1000) begin bad++; $display("FAIL swl_req got=%b/%h/%h exp=0011/00001122/1000", q_strobe, q_data, q_addr); end
        run_op(MEM_SWR, 32'h1001, 32'h11223344, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_strobe !== 4'b1110 || q_data !== 32'h22334400 || q_addr !== 32'h1000) begin bad++; $display("FAIL swr_req got=%b/%h/%h exp=1110/22334400/1000", q_strobe, q_data, q_addr); end
        run_op(MEM_SW, 32'h1004, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_strobe !== 4'b1111 || q_data !== 32'hCAFEF00D || q_out !== 32'h0) begin bad++; $display("FAIL sw_req got=%b/%h/%h exp=1111/cafef00d/0", q_strobe, q_data, q_out); end
    endtask

    task automatic test_stall();
        run_op(MEM_LW, 32'h1008, 32'h0, 32'h0, 32'h0BADF00D, 5, 0, 3);
        total++; if (req_stable !== 1'b1 || req_cycles !== 6) begin bad++; $display("FAIL stall_req got=stable%b/cyc%0d exp=1/6", req_stable, req_cycles); end
        total++; if (done_stable !== 1'b1 || q_out !== 32'h0BADF00D) begin bad++; $display("FAIL stall_done got=%b/%h exp=1/0badf00d", done_stable, q_out); end
        total++; if (ready_after !== 1'b1) begin bad++; $display("FAIL stall_back_idle got=%b exp=1", ready_after); end
    endtask

    task automatic test_back_to_back();
        run_op(MEM_LW, 32'h2000, 32'h0, 32'h0, 32'h13579BDF, 0, 0, 0);
        total++; if (latency !== 1) begin bad++; $display("FAIL latency got=%0d exp=1", latency); end
        run_op(MEM_NONE, 32'h2000, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0, 0);
        total++; if (q_out !== 32'h0 || saw_req !== 1'b0 || latency !== 0) begin bad++; $display("FAIL none_op got=%h/%b/%0d exp=0/0/0", q_out, saw_req, latency); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1; in_op = MEM_LW; in_addr = 32'h5000;
        @(posedge clk); #1;
        in_valid = 0; in_op = MEM_NONE; in_addr = '0;
        dresp_addr_ok = 1;
        @(posedge clk); #1;
        dresp_addr_ok = 0;
        total++; if (dreq_valid !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL wait_state got=%b%b%b exp=000", dreq_valid, in_ready, out_valid); end
        #2 reset = 1;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL async_rst got=%b/%b exp=1/0", in_ready, out_valid); end
        @(posedge clk); #1 reset = 0;
        dresp_data_ok = 1; dresp_data = 32'h99999999;
        @(posedge clk); #1;
        dresp_data_ok = 0; dresp_data = '0;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0) begin bad++; $display("FAIL late_dok got=%b/%b/%b exp=0/1/0", out_valid, in_ready, dreq_valid); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sb();
        test_misalign();
        test_loads();
        test_store_lanes();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_lsu.md
MEMORY_LSU -- requirements
Module: memory_lsu

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-003 in_valid  in  1  execute stage presents a memory op.
REQ-004 in_ready  out  1  unit accepts the op this cycle; asserted only in IDLE.
REQ-005 in_op  in  mem_op_t  one of NONE, LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR.
REQ-006 in_addr  in  32  effective address (vs + sign-extended imm) from the execute ALU.
REQ-007 in_wdata  in  32  store source (rt value).
REQ-008 in_rt_old  in  32  current rt value, used for LWL/LWR merge.
REQ-009 dreq_valid / dreq_addr / dreq_size / dreq_strobe / dreq_data  out  1/32/2/4/32  data-bus request; size 0=byte, 1=half, 2=word.
REQ-010 dresp_addr_ok / dresp_data_ok / dresp_data  in  1/1/32  bus accept, completion, read data.
REQ-011 out_valid / out_ready  out/in  1/1  result handshake to writeback.
REQ-012 out_data / out_exc_adel / out_exc_ades / out_badvaddr  out  32/1/1/32  load result, load/store address error, faulting address.

Function
REQ-013 FSM states IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-014 IDLE: on in_valid, capture op/addr/wdata/rt_old; go REQ if address legal, else DONE with exception.
REQ-015 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; violation sets ADEL (loads) or ADES (stores), badvaddr=in_addr, no bus request ever issued.
REQ-016 NONE op: go directly to DONE, out_data=0, no bus activity.
REQ-017 REQ: dreq_valid=1 with stable fields until dresp_addr_ok; same-cycle addr_ok and data_ok goes straight to DONE, addr_ok alone goes to WAIT.
REQ-018 WAIT: hold until dresp_data_ok; latch dresp_data (loads) then go DONE.
REQ-019 DONE: out_valid=1, outputs stable until out_ready; on out_ready return to IDLE; no new op accepted in the same cycle.
REQ-020 Byte lanes little-endian, a=addr[1:0]; dreq_addr=addr for LB..SW, {addr[31:2],2'b00} with size=word for LWL/LWR/SWL/SWR.
REQ-021 Strobes: loads 0000; SB 0001<<a; SH 0011<<a; SW 1111; SWL a=0..3 -> 0001,0011,0111,1111; SWR a=0..3 -> 1111,1110,1100,1000.
REQ-022 Store data: SB {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata; SWL wdata>>(8*(3-a)); SWR wdata<<(8*a).
REQ-023 Loads: LB/LBU select byte a, sign-/zero-extend; LH/LHU select half a[1], sign-/zero-extend; LW full word.
REQ-024 LWL a=0..3 -> {m[7:0],rt[23:0]}, {m[15:0],rt[15:0]}, {m[23:0],rt[7:0]}, m.
REQ-025 LWR a=0..3 -> m, {rt[31:24],m[31:8]}, {rt[31:16],m[31:16]}, {rt[31:8],m[31:24]}.
REQ-026 Stores complete with out_data=0; exception flags are 0 on every non-faulting op.
REQ-027 Latency with zero-wait bus and out_ready=1: accept cycle N, request N+1, out_valid N+2.

Reset
REQ-028 Reset drives IDLE, dreq_valid=0, out_valid=0, in_ready=1, all data/flag outputs 0, latched fields 0.
REQ-029 Reset mid-transaction abandons the op; a late dresp_data_ok after reset in IDLE is ignored.

Structure
REQ-030 mem_op_t, size encodings and the exception flag struct live in the shared mycpu package.
REQ-031 Load-alignment/extension (REQ-023..025) is one combinational sub-module, lsu_load_align; all remaining logic in memory_lsu.

Verification
REQ-032 LW addr 0x1000, addr_ok and data_ok one cycle apart, data 0xDEADBEEF -> out_data 0xDEADBEEF, strobe 0000, one request.
REQ-033 SB addr 0x1003, wdata 0x000000A5 -> strobe 1000, dreq_data 0xA5A5A5A5, out_valid no exception.
REQ-034 LH addr 0x2001 -> ADEL=1, badvaddr 0x2001, dreq_valid never asserted.
REQ-035 LWL addr 0x3001, mem 0x11223344, rt 0xAABBCCDD -> 0x3344CCDD; LWR same -> 0xAA112233.
REQ-036 addr_ok held low 5 cycles -> dreq fields stable throughout; out_ready low 3 cycles in DONE -> outputs stable, in_ready=0.
REQ-037 Reset asserted in WAIT, then data_ok pulses -> state IDLE, out_valid stays 0.
